// File: rtl/branch_predictor_table.sv
// Direction-only branch predictor: gshare (or bimodal when HIST_BITS=0) table of saturating counters.
// Define BPU_STATS_EN to add saturating update/mispredict statistics outputs.
module branch_predictor_table #(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      lookup_pc,
  output logic [INDEX_BITS-1:0] lookup_index,
  output logic                  prediction,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]           stat_updates,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

  logic [CTR_BITS-1:0]   ctr_table [ENTRIES];
  logic [CTR_BITS-1:0]   upd_ctr;
  logic [CTR_BITS-1:0]   upd_ctr_next;
  logic [CTR_BITS-1:0]   lookup_ctr;
  logic [INDEX_BITS-1:0] hist_ext;
  logic                  upd_fire;
  logic                  bypass_hit;
  logic                  unused_bits;

  assign upd_fire = en & upd_valid;
  assign upd_ctr  = ctr_table[upd_index];

  always_comb begin
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) upd_ctr_next = upd_ctr - 1'b1;
    end
  end

  generate
    if (HIST_BITS == 0) begin : g_bimodal
      assign hist_ext = '0;
    end else begin : g_gshare
      logic [HIST_BITS-1:0] ghr;
      logic [HIST_BITS-1:0] ghr_next;

      if (HIST_BITS == 1) begin : g_hist1
        assign ghr_next = upd_taken;
      end else begin : g_histn
        assign ghr_next = {ghr[HIST_BITS-2:0], upd_taken};
      end

      // History is trained at resolution only, never speculatively at fetch.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ghr <= '0;
        end else if (upd_fire) begin
          ghr <= ghr_next;
        end
      end

      assign hist_ext = INDEX_BITS'(ghr);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= CTR_INIT;
    end else if (upd_fire) begin
      ctr_table[upd_index] <= upd_ctr_next;
    end
  end

  assign lookup_index = lookup_pc[INDEX_BITS+1:2] ^ hist_ext;

  // Write-through bypass covers the counter only; the index sees new history next cycle.
  assign bypass_hit = upd_fire & rst & (upd_index == lookup_index);
  assign lookup_ctr = bypass_hit ? upd_ctr_next : ctr_table[lookup_index];
  assign prediction = lookup_ctr[CTR_BITS-1];

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (upd_fire) begin
      if (stat_updates != '1) stat_updates <= stat_updates + 32'd1;
      if (upd_mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

  assign unused_bits = ^{lookup_pc[WIDTH-1:INDEX_BITS+2], lookup_pc[1:0]};
`else
  assign unused_bits = ^{lookup_pc[WIDTH-1:INDEX_BITS+2], lookup_pc[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor_table.sv
// Scoreboard bench for branch_predictor_table with default parameters (64 entries, 2-bit counters, 6-bit history).
// Stats checks are compiled in when BPU_STATS_EN is defined.
module tb_branch_predictor_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] lookup_pc;
  logic [5:0]  lookup_index;
  logic        prediction;
  logic        upd_valid;
  logic [5:0]  upd_index;
  logic        upd_taken;
  logic        upd_mispredict;
`ifdef BPU_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
  int unsigned st_upd_m;
  int unsigned st_mis_m;
`endif

  always #5 clk = ~clk;

  branch_predictor_table dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .lookup_pc      (lookup_pc),
    .lookup_index   (lookup_index),
    .prediction     (prediction),
    .upd_valid      (upd_valid),
    .upd_index      (upd_index),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict)
`ifdef BPU_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    string      tag;
    logic [5:0] idx;
    logic       pred;
  } exp_t;

  exp_t       exp_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [1:0] ctr_m [64];
  logic [5:0] ghr_m;

  task automatic modelReset();
    for (int i = 0; i < 64; i++) ctr_m[i] = 2'b01;
    ghr_m = '0;
`ifdef BPU_STATS_EN
    st_upd_m = 0;
    st_mis_m = 0;
`endif
  endtask

  function automatic logic [1:0] ctrNext(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [31:0] pcFor(input logic [5:0] idx);
    return {24'h0, idx ^ ghr_m, 2'b00};
  endfunction

  // Expected outputs for the inputs currently driven, from the model's pre-edge state.
  task automatic pushExpected(input string tag);
    exp_t       x;
    logic [5:0] idx;
    logic [1:0] c;
    idx = lookup_pc[7:2] ^ ghr_m;
    c   = ctr_m[idx];
    if (en && upd_valid && rst && (upd_index == idx)) c = ctrNext(ctr_m[idx], upd_taken);
    x.tag  = tag;
    x.idx  = idx;
    x.pred = c[1];
    exp_q.push_back(x);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] pc, input logic e, input logic v,
                               input logic [5:0] ui, input logic t, input logic m);
    @(negedge clk);
    lookup_pc      = pc;
    en             = e;
    upd_valid      = v;
    upd_index      = ui;
    upd_taken      = t;
    upd_mispredict = m;
    pushExpected(tag);
    if (e && v && rst) begin
      ctr_m[ui] = ctrNext(ctr_m[ui], t);
      ghr_m     = {ghr_m[4:0], t};
`ifdef BPU_STATS_EN
      st_upd_m++;
      if (m) st_mis_m++;
`endif
    end
  endtask

  task automatic checkOutput();
    exp_t x;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("[TB] FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    x = exp_q.pop_front();
    tests_run++;
    assert (lookup_index === x.idx) else begin
      tests_failed++;
      $error("[TB] FAIL %s lookup_index observed %h expected %h", x.tag, lookup_index, x.idx);
    end
    tests_run++;
    assert (prediction === x.pred) else begin
      tests_failed++;
      $error("[TB] FAIL %s prediction observed %b expected %b", x.tag, prediction, x.pred);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    assert (got === want) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic stepCheck(input string tag, input logic [31:0] pc, input logic e, input logic v,
                           input logic [5:0] ui, input logic t, input logic m);
    applyStimulus(tag, pc, e, v, ui, t, m);
    #1 checkOutput();
  endtask

  // Update one index, then look at it again on an idle cycle to see the stored value.
  task automatic trainLook(input string tag, input logic [5:0] idx, input logic t);
    stepCheck(tag, pcFor(idx), 1'b1, 1'b1, idx, t, t != ctr_m[idx][1]);
    stepCheck(tag, pcFor(idx), 1'b1, 1'b0, idx, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges must take effect without waiting for a clock.
  task automatic asyncReset(input string tag);
    @(posedge clk);
    #2;
    upd_valid = 1'b0;
    rst       = 1'b0;
    modelReset();
    for (int k = 0; k < 3; k++) begin
      if (k != 0) lookup_pc = $urandom;
      pushExpected(tag);
      #1 checkOutput();
    end
`ifdef BPU_STATS_EN
    checkValue({tag, "_stat_updates"}, stat_updates, 32'd0);
    checkValue({tag, "_stat_mispredicts"}, stat_mispredicts, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [5:0]  ri;
    logic [31:0] rpc;
    logic        re;
    logic        rv;
    logic        rt;

    rst            = 1'b0;
    en             = 1'b1;
    lookup_pc      = 32'h24;
    upd_valid      = 1'b1;
    upd_index      = 6'd9;
    upd_taken      = 1'b1;
    upd_mispredict = 1'b1;
    modelReset();

    // Held in reset with a live update request: nothing may move, prediction stays 0.
    #2 pushExpected("in_reset");
    #1 checkOutput();
    @(posedge clk);
    @(posedge clk);
    #2 pushExpected("in_reset_after_edges");
    #1 checkOutput();
    @(negedge clk);
    upd_valid = 1'b0;
    rst       = 1'b1;

    for (int p = 0; p < 64; p++) stepCheck("reset_sweep", 32'(p * 4), 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);

    stepCheck("bypass", 32'h24, 1'b1, 1'b1, 6'd9, 1'b1, 1'b1);
    checkValue("bypass_pred", {31'd0, prediction}, 32'd1);
    asyncReset("reset_after_bypass");

    for (int k = 0; k < 5; k++) trainLook("sat_taken", 6'd5, 1'b1);
    for (int k = 0; k < 5; k++) trainLook("sat_not_taken", 6'd5, 1'b0);
    trainLook("sat_floor", 6'd5, 1'b1);
    asyncReset("reset_after_sat");

    for (int k = 0; k < 3; k++) stepCheck("hist_train", 32'h0, 1'b1, 1'b1, 6'h3f, 1'b1, 1'b0);
    stepCheck("hist_lookup", 32'h40, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    checkValue("hist_index", {26'd0, lookup_index}, 32'h17);

    for (int k = 0; k < 4; k++) stepCheck("stall", pcFor(6'h3f), 1'b0, 1'b1, 6'h3f, 1'b0, 1'b1);
    stepCheck("stall_resume", pcFor(6'h3f), 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    checkValue("stall_index", {26'd0, lookup_index}, 32'h3f);
    checkValue("stall_pred", {31'd0, prediction}, 32'd1);
    trainLook("stall_resume_train", 6'h3f, 1'b0);

    for (int k = 0; k < 400; k++) begin
      ri  = 6'($urandom_range(0, 63));
      rpc = ($urandom_range(0, 3) == 0) ? pcFor(ri) : $urandom;
      re  = ($urandom_range(0, 7) != 0);
      rv  = ($urandom_range(0, 3) != 0);
      rt  = $urandom_range(0, 1) == 1;
      stepCheck("random", rpc, re, rv, ri, rt, rt != ctr_m[ri][1]);
    end
`ifdef BPU_STATS_EN
    checkValue("random_stat_updates", stat_updates, st_upd_m);
    checkValue("random_stat_mispredicts", stat_mispredicts, st_mis_m);
`endif

    asyncReset("reset_before_stats");
    for (int k = 0; k < 10; k++) stepCheck("stats_train", pcFor(6'(k)), 1'b1, 1'b1, 6'(k), 1'b1, k < 3);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
`ifdef BPU_STATS_EN
    checkValue("stats_updates", stat_updates, 32'd10);
    checkValue("stats_mispredicts", stat_mispredicts, 32'd3);
`endif
    asyncReset("reset_mid_run");
    for (int p = 0; p < 16; p++) stepCheck("post_reset_sweep", 32'(p * 4), 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
